ifetch_queue: RTL and testbench

Instruction fetch front end: the initiator that drives the instruction memory's combinational read port and buffers fetched words for the decode stage. It holds the fetch PC, issues `iaddr` every cycle, and captures `idata` into a small prefetch FIFO. It presents `{pc, inst}` to decode with a valid/ready handshake and handles redirects from branch/jump resolution by flushing the FIFO. It sits between the instruction memory and the IF/ID pipeline register.

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifetch_fifo.sv | 69 ++++++
 rtl/ifetch_queue.sv | 103 ++++++++++
 tb/tb_ifetch_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction fetch front end: reset PC, default
// prefetch depth, FIFO entry layout and the sequential PC step.
package ifetch_queue_pkg;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
    localparam int          IFETCH_DEPTH    = 4;
    localparam int          ENTRY_W         = 64;
    localparam logic [31:0] INST_BYTES      = 32'd4;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Generic synchronous FIFO with flush. Pointers carry one extra wrap bit so
// that full and empty are distinguishable without a separate counter.
// Read data is the head entry, combinationally from storage.
module ifetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = IFETCH_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    // Pointer and storage next-state; flush empties the FIFO and blocks the write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // State registers; storage is cleared so the head reads as zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Status flags and head read.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, drives the instruction
// memory address every cycle, buffers {pc, inst} in a prefetch FIFO and
// hands entries to decode with valid/ready. Redirects reload the PC and
// flush the FIFO. `rst` is asynchronous, active-low.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to fault on misaligned
// redirect targets and stall fetching until an aligned redirect.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
    parameter int          DEPTH    = IFETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               fault;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    // Fault tracks the alignment of the most recent redirect target.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    // Fault flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Handshake and fetch PC next-state; a redirect overrides any push.
    always_comb begin
        pop        = out_valid & out_ready;
        push       = !redirect_valid & !fault & (!full | pop);
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (push) begin
            fetch_pc_d = next_pc(fetch_pc_q);
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data ({fetch_pc_q, idata}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Output mapping from the FIFO head and fetch PC.
    always_comb begin
        iaddr     = fetch_pc_q;
        out_valid = !empty;
        out_pc    = head[ENTRY_W-1:32];
        out_inst  = head[31:0];
        out_fault = fault;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    int checks = 0;
    int errors = 0;
    bit mem_mode = 1'b0;

    ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .iaddr          (iaddr),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: word = address, or a scrambled word in random mode.
    assign idata = mem_mode ? hash(iaddr) : iaddr;

    function automatic logic [31:0] memw(input bit mode, input logic [31:0] a);
        return mode ? hash(a) : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched words plus the fetch PC and fault flag.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mfault;
    bit          model_on = 1'b0;

    task automatic model_check();
        chk("m_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        chk("m_iaddr", iaddr, mpc);
        chk("m_fault", {31'b0, out_fault}, {31'b0, mfault});
        if (mq.size() > 0) begin
            chk("m_pc", out_pc, mq[0].pc);
            chk("m_inst", out_inst, mq[0].inst);
        end
    endtask

    task automatic model_update(input logic rv, input logic [31:0] rpc, input logic rdy);
        int sz;
        bit pop;
        sz  = mq.size();
        pop = (sz > 0) && rdy;
        if (rv) begin
            mq.delete();
            mpc = rpc;
`ifdef IFETCH_ALIGN_CHECK_EN
            mfault = (rpc[1:0] != 2'b00);
`endif
        end else begin
            if (pop) void'(mq.pop_front());
            if (!mfault && (sz < DEPTH || pop)) begin
                mq.push_back('{mpc, memw(mem_mode, mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later, then clock.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        if (model_on) model_check();
        model_update(rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_iaddr", iaddr, RESET_PC);
        chk("rst_fault", {31'b0, out_fault}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        mq.delete();
        mpc    = RESET_PC;
        mfault = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[28];

    initial begin
        // rv, rpc, rdy | expected valid, pc (= inst), iaddr
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h4};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'h8};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         32'hC};
        for (int i = 4; i < 10; i++)
            tbl[i] = '{1'b0, 32'h0,      1'b0, 1'b1, 32'h0,         32'h10};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h10};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h14};
        tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h18};
        tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h1C};
        tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        32'h20};
        tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h14,        32'h24};
        tbl[16] = '{1'b1, 32'h100,       1'b1, 1'b1, 32'h18,        32'h28};
        tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h100};
        tbl[18] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       32'h104};
        tbl[19] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h104,       32'h108};
        tbl[20] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'hFFFF_FFF8};
        tbl[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        tbl[22] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0};
        tbl[23] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h4};
        tbl[24] = '{1'b1, 32'h300,       1'b1, 1'b1, 32'h4,         32'h8};
        tbl[25] = '{1'b1, 32'h400,       1'b1, 1'b0, 32'h0,         32'h300};
        tbl[26] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h400};
        tbl[27] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h400,       32'h404};

        // Directed table: fill, stall, drain, redirects, PC wrap, back-to-back redirects.
        mem_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_iaddr", i), iaddr, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_inst", i), out_inst, tbl[i].epc);
            end
            chk($sformatf("tbl%0d_fault", i), {31'b0, out_fault}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset with three entries buffered.
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0);
        #1;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("pre_rst_iaddr", iaddr, 32'hC);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_iaddr", iaddr, RESET_PC);
        chk("async_rst_fault", {31'b0, out_fault}, 32'd0);
        @(negedge clk);

        // Misaligned redirect handling.
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h102, 1'b1);
        #1;
        chk("mis_iaddr", iaddr, 32'h102);
        chk("mis_valid0", {31'b0, out_valid}, 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'b0, out_fault}, 32'd1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        #1;
        chk("mis_stall_valid", {31'b0, out_valid}, 32'd0);
        chk("mis_stall_iaddr", iaddr, 32'h102);
        chk("mis_stall_fault", {31'b0, out_fault}, 32'd1);
        step(1'b1, 32'h200, 1'b1);
        #1;
        chk("clr_fault", {31'b0, out_fault}, 32'd0);
        chk("clr_iaddr", iaddr, 32'h200);
        step(1'b0, 32'h0, 1'b1);
        #1;
        chk("clr_valid", {31'b0, out_valid}, 32'd1);
        chk("clr_pc", out_pc, 32'h200);
`else
        chk("mis_fault", {31'b0, out_fault}, 32'd0);
        step(1'b0, 32'h0, 1'b1);
        #1;
        chk("mis_valid1", {31'b0, out_valid}, 32'd1);
        chk("mis_pc", out_pc, 32'h102);
        chk("mis_next_iaddr", iaddr, 32'h106);
        chk("mis_fault_hold", {31'b0, out_fault}, 32'd0);
`endif
        @(negedge clk);

        // Randomized traffic against the reference model.
        mem_mode = 1'b1;
        do_reset();
        model_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic        rv;
            logic        rdy;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0;
                default: rpc = $urandom & 32'hFFFF_FFFC;
            endcase
            step(rv, rpc, rdy);
        end
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
